data_frame_pack: RTL and testbench



---
 rtl/data_frame_pack.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_data_frame_pack.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_frame_pack.sv
// data_frame_pack
// Stores packets from the post-side stream (no backpressure) and wraps each
// stored packet into a byte frame: HEAD0, HEAD1, LEN, payload[, CHECKSUM].
// Frames leave on a valid/ready byte interface toward the host-link TX.
// If the RAM or the length queue overflows, the whole packet is dropped.
//
// Ports:
//   i_post_clk, i_post_rst_n     clock, async active-low reset
//   i_data/i_len/i_last/i_valid  incoming packet stream
//   o_tx_data/o_tx_valid         frame byte out, i_tx_ready accepts it
//   o_drop, o_drop_cnt           drop pulse and saturating drop count
//   o_busy                       frame in progress or packets queued
//
// Build option: define FRAME_CHKSUM_EN to append the checksum byte
// (sum mod 256 of LEN and payload). Otherwise frames end after the payload.
module data_frame_pack #(
    parameter logic [7:0] HEAD0   = 8'h55,
    parameter logic [7:0] HEAD1   = 8'hAA,
    parameter int         DATA_AW = 9,
    parameter int         LEN_AW  = 3
) (
    input  logic        i_post_clk,
    input  logic        i_post_rst_n,
    input  logic [7:0]  i_data,
    input  logic [7:0]  i_len,
    input  logic        i_last,
    input  logic        i_valid,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic        o_drop,
    output logic [15:0] o_drop_cnt,
    output logic        o_busy
);

    localparam int DEPTH    = 1 << DATA_AW;
    localparam int LQ_DEPTH = 1 << LEN_AW;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_H0   = 3'd1,
        S_H1   = 3'd2,
        S_LEN  = 3'd3,
        S_PAY  = 3'd4
`ifdef FRAME_CHKSUM_EN
        ,
        S_CHK  = 3'd5
`endif
    } state_t;

    logic [7:0]         mem_q    [DEPTH];
    logic [7:0]         lq_mem_q [LQ_DEPTH];

    // Write side state
    logic [DATA_AW:0]   wr_ptr_q, wr_ptr_d;
    logic [DATA_AW:0]   start_q, start_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [7:0]         len_q, len_d;
    logic               in_pkt_q, in_pkt_d;
    logic               skip_q, skip_d;
    logic               drop_q;
    logic [15:0]        drop_cnt_q, drop_cnt_d;
    logic [LEN_AW:0]    lq_wr_q, lq_wr_d;

    // Read side state
    state_t             state_q;
    logic [DATA_AW:0]   rd_ptr_q;
    logic [LEN_AW:0]    lq_rd_q;
    logic [7:0]         tx_data_q;
    logic               tx_valid_q;
    logic [7:0]         rem_q;
    logic [7:0]         len_cur_q;
`ifdef FRAME_CHKSUM_EN
    logic [7:0]         sum_q;
`endif

    logic [7:0]         eff_len_s;
    logic [DATA_AW:0]   used_s;
    logic               ram_full_s;
    logic [LEN_AW+1:0]  lq_occ_s;
    logic               lq_full_s;
    logic               want_s, acc_s, full_drop_s, end_s, push_s, drop_s;
    logic [7:0]         cnt_new_s;
    logic [DATA_AW:0]   wr_inc_s;
    logic               hs_s;
    logic [DATA_AW:0]   rd_nxt_s;

    // The length is taken from the port until the first byte latches it.
    assign eff_len_s  = in_pkt_q ? len_q : i_len;
    assign used_s     = wr_ptr_q - rd_ptr_q;
    assign ram_full_s = used_s[DATA_AW];
    // A frame being emitted still holds its queue slot until it completes.
    assign lq_occ_s   = {1'b0, lq_wr_q - lq_rd_q} + {{(LEN_AW+1){1'b0}}, (state_q != S_IDLE)};
    assign lq_full_s  = |lq_occ_s[LEN_AW+1:LEN_AW];

    assign want_s      = i_valid & ~skip_q & (cnt_q < eff_len_s);
    assign full_drop_s = want_s & ram_full_s;
    assign acc_s       = want_s & ~ram_full_s;
    assign cnt_new_s   = cnt_q + {7'd0, acc_s};
    assign wr_inc_s    = wr_ptr_q + {{DATA_AW{1'b0}}, acc_s};
    // Packet end that needs a decision; len==0 packets end silently.
    assign end_s       = i_last & ~skip_q & ~full_drop_s & (eff_len_s != 8'd0);
    assign push_s      = end_s & (cnt_new_s == eff_len_s) & ~lq_full_s;
    assign drop_s      = full_drop_s | (end_s & ~push_s);

    // Write side next-state: speculative pointer, commit, rewind, drop count
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        start_d    = start_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        in_pkt_d   = in_pkt_q;
        skip_d     = skip_q;
        drop_cnt_d = drop_cnt_q;
        lq_wr_d    = lq_wr_q;

        if (drop_s) begin
            wr_ptr_d = start_q;
        end else begin
            wr_ptr_d = wr_inc_s;
        end

        if (push_s) begin
            start_d = wr_inc_s;
            lq_wr_d = lq_wr_q + {{LEN_AW{1'b0}}, 1'b1};
        end else begin
            start_d = start_q;
            lq_wr_d = lq_wr_q;
        end

        if (drop_s && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end else begin
            drop_cnt_d = drop_cnt_q;
        end

        if (i_last) begin
            cnt_d    = 8'd0;
            in_pkt_d = 1'b0;
            skip_d   = 1'b0;
        end else if (full_drop_s) begin
            cnt_d    = 8'd0;
            in_pkt_d = 1'b1;
            skip_d   = 1'b1;
        end else if (i_valid && !skip_q) begin
            cnt_d    = cnt_new_s;
            in_pkt_d = 1'b1;
            len_d    = eff_len_s;
        end else begin
            cnt_d    = cnt_q;
        end
    end

    // Write side registers
    always_ff @(posedge i_post_clk or negedge i_post_rst_n) begin
        if (!i_post_rst_n) begin
            wr_ptr_q   <= '0;
            start_q    <= '0;
            cnt_q      <= 8'd0;
            len_q      <= 8'd0;
            in_pkt_q   <= 1'b0;
            skip_q     <= 1'b0;
            drop_q     <= 1'b0;
            drop_cnt_q <= 16'd0;
            lq_wr_q    <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            start_q    <= start_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            in_pkt_q   <= in_pkt_d;
            skip_q     <= skip_d;
            drop_q     <= drop_s;
            drop_cnt_q <= drop_cnt_d;
            lq_wr_q    <= lq_wr_d;
        end
    end

    // Payload RAM and length queue storage (contents need no reset)
    always_ff @(posedge i_post_clk) begin
        if (acc_s) begin
            mem_q[wr_ptr_q[DATA_AW-1:0]] <= i_data;
        end
        if (push_s) begin
            lq_mem_q[lq_wr_q[LEN_AW-1:0]] <= eff_len_s;
        end
    end

    assign hs_s     = tx_valid_q & i_tx_ready;
    assign rd_nxt_s = rd_ptr_q + {{DATA_AW{1'b0}}, 1'b1};

    // Frame FSM: output byte is registered; the next payload byte is fetched
    // at the handshake of the current one so PAY runs without bubbles.
    always_ff @(posedge i_post_clk or negedge i_post_rst_n) begin
        if (!i_post_rst_n) begin
            state_q    <= S_IDLE;
            rd_ptr_q   <= '0;
            lq_rd_q    <= '0;
            tx_data_q  <= 8'd0;
            tx_valid_q <= 1'b0;
            rem_q      <= 8'd0;
            len_cur_q  <= 8'd0;
`ifdef FRAME_CHKSUM_EN
            sum_q      <= 8'd0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (lq_wr_q != lq_rd_q) begin
                        len_cur_q  <= lq_mem_q[lq_rd_q[LEN_AW-1:0]];
                        lq_rd_q    <= lq_rd_q + {{LEN_AW{1'b0}}, 1'b1};
                        tx_data_q  <= HEAD0;
                        tx_valid_q <= 1'b1;
                        state_q    <= S_H0;
                    end else begin
                        tx_valid_q <= 1'b0;
                    end
                end
                S_H0: begin
                    if (hs_s) begin
                        tx_data_q <= HEAD1;
                        state_q   <= S_H1;
                    end
                end
                S_H1: begin
                    if (hs_s) begin
                        tx_data_q <= len_cur_q;
`ifdef FRAME_CHKSUM_EN
                        sum_q     <= len_cur_q;
`endif
                        state_q   <= S_LEN;
                    end
                end
                S_LEN: begin
                    if (hs_s) begin
                        tx_data_q <= mem_q[rd_ptr_q[DATA_AW-1:0]];
                        rem_q     <= len_cur_q;
                        state_q   <= S_PAY;
                    end
                end
                S_PAY: begin
                    if (hs_s) begin
                        rd_ptr_q <= rd_nxt_s;
                        rem_q    <= rem_q - 8'd1;
`ifdef FRAME_CHKSUM_EN
                        sum_q    <= sum_q + tx_data_q;
`endif
                        if (rem_q == 8'd1) begin
`ifdef FRAME_CHKSUM_EN
                            tx_data_q <= sum_q + tx_data_q;
                            state_q   <= S_CHK;
`else
                            tx_valid_q <= 1'b0;
                            state_q    <= S_IDLE;
`endif
                        end else begin
                            tx_data_q <= mem_q[rd_nxt_s[DATA_AW-1:0]];
                        end
                    end
                end
`ifdef FRAME_CHKSUM_EN
                S_CHK: begin
                    if (hs_s) begin
                        tx_valid_q <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                end
`endif
                default: begin
                    tx_valid_q <= 1'b0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    assign o_tx_data  = tx_data_q;
    assign o_tx_valid = tx_valid_q;
    assign o_drop     = drop_q;
    assign o_drop_cnt = drop_cnt_q;
    assign o_busy     = (state_q != S_IDLE) | (lq_wr_q != lq_rd_q);

endmodule

// File: tb/tb_data_frame_pack.sv
// Self-checking bench for data_frame_pack: directed scenarios plus randomized
// packets, compared against a packet-level reference model of the frames.
module tb_data_frame_pack;

    localparam int RAM_DEPTH = 512;
    localparam int LQ_DEPTH  = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  i_data, i_len;
    logic        i_last, i_valid, i_tx_ready;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid, o_drop, o_busy;
    logic [15:0] o_drop_cnt;

    always #5 clk = ~clk;

    data_frame_pack dut (
        .i_post_clk   (clk),
        .i_post_rst_n (rst_n),
        .i_data       (i_data),
        .i_len        (i_len),
        .i_last       (i_last),
        .i_valid      (i_valid),
        .o_tx_data    (o_tx_data),
        .o_tx_valid   (o_tx_valid),
        .i_tx_ready   (i_tx_ready),
        .o_drop       (o_drop),
        .o_drop_cnt   (o_drop_cnt),
        .o_busy       (o_busy)
    );

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];
    logic [7:0] pkt_data [256];
    int model_used = 0, model_out = 0, model_drops = 0;
    int drop_pulses = 0, hs_cnt = 0;
    int ready_mode = 0;
    logic prev_stall = 1'b0;
    logic [7:0] prev_data = 8'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int fl(input int len);
`ifdef FRAME_CHKSUM_EN
        return len + 4;
`else
        return len + 3;
`endif
    endfunction

    // Reference model: whole-packet decision and expected frame bytes.
    task automatic model_pkt(input int len, input int n);
        int acc;
        int s;
        acc = (n < len) ? n : len;
        if (len == 0) return;
        if (acc < len || model_used + len > RAM_DEPTH || model_out >= LQ_DEPTH) begin
            model_drops++;
        end else begin
            model_used += len;
            model_out++;
            exp_q.push_back(8'h55);
            exp_q.push_back(8'hAA);
            exp_q.push_back(8'(len));
            s = len;
            for (int k = 0; k < len; k++) begin
                exp_q.push_back(pkt_data[k]);
                s += int'(pkt_data[k]);
            end
`ifdef FRAME_CHKSUM_EN
            exp_q.push_back(8'(s));
`endif
        end
    endtask

    // Output monitor: frame bytes, stall stability, drop pulses.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 32'(o_tx_valid), 32'd1);
                chk("stall_data", 32'(o_tx_data), 32'(prev_data));
            end
            if (o_drop) drop_pulses++;
            if (o_tx_valid && i_tx_ready) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $error("FAIL unexpected_byte observed=%0h expected=none", o_tx_data);
                end else begin
                    chk("tx_byte", 32'(o_tx_data), 32'(exp_q.pop_front()));
                end
            end
            prev_stall = o_tx_valid && !i_tx_ready;
            prev_data  = o_tx_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        case (ready_mode)
            0: i_tx_ready = 1'b0;
            1: i_tx_ready = 1'b1;
            2: i_tx_ready = ~i_tx_ready;
            default: i_tx_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic send_pkt(input int len, input int n, input bit sep_last);
        bit sep;
        sep = sep_last || (n == 0);
        i_len = 8'(len);
        tick();
        for (int k = 0; k < n; k++) begin
            i_valid = 1'b1;
            i_data  = pkt_data[k];
            i_last  = (!sep && k == n - 1);
            tick();
        end
        i_valid = 1'b0;
        i_last  = 1'b0;
        if (sep) begin
            i_last = 1'b1;
            tick();
            i_last = 1'b0;
        end
        model_pkt(len, n);
    endtask

    task automatic drain(input int budget, input string tag);
        int k;
        k = 0;
        while ((o_busy === 1'b1 || exp_q.size() != 0) && k < budget) begin
            tick();
            k++;
        end
        chk(tag, 32'(k < budget), 32'd1);
        chk("exp_empty", 32'(exp_q.size()), 32'd0);
        model_used = 0;
        model_out  = 0;
    endtask

    task automatic set4();
        pkt_data[0] = 8'h11; pkt_data[1] = 8'h22;
        pkt_data[2] = 8'h33; pkt_data[3] = 8'h44;
    endtask

    initial begin
        int k;
        int hs0;
        int len, n, r;
        rst_n = 1'b0; i_data = 8'd0; i_len = 8'd0; i_last = 1'b0;
        i_valid = 1'b0; i_tx_ready = 1'b0;
        repeat (3) tick();
        chk("rst_tx_data", 32'(o_tx_data), 32'd0);
        chk("rst_tx_valid", 32'(o_tx_valid), 32'd0);
        chk("rst_drop", 32'(o_drop), 32'd0);
        chk("rst_drop_cnt", 32'(o_drop_cnt), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        rst_n = 1'b1;
        tick();

        // Packet 11 22 33 44 with ready high: contiguous frame, busy falls after it
        ready_mode = 1;
        set4();
        send_pkt(4, 4, 1'b0);
        k = 0;
        while (o_tx_valid !== 1'b1 && k < 20) begin tick(); k++; end
        chk("t1_start", 32'(k < 20), 32'd1);
        for (int i = 0; i < fl(4); i++) begin
            chk("t1_no_bubble", 32'(o_tx_valid), 32'd1);
            tick();
        end
        chk("t1_busy_fall", 32'(o_busy), 32'd0);
        chk("t1_valid_fall", 32'(o_tx_valid), 32'd0);
        drain(50, "t1_drain");

        // Same packet with ready toggling
        ready_mode = 2;
        set4();
        send_pkt(4, 4, 1'b0);
        drain(200, "t2_drain");

        // RAM overflow: three 255-byte packets with ready low
        ready_mode = 0;
        for (int p = 0; p < 3; p++) begin
            for (int b = 0; b < 255; b++) pkt_data[b] = 8'($urandom);
            send_pkt(255, 255, 1'b0);
        end
        repeat (3) tick();
        chk("t3_drop_cnt", 32'(o_drop_cnt), 32'(model_drops));
        chk("t3_drop_pulses", 32'(drop_pulses), 32'(model_drops));
        hs0 = hs_cnt;
        ready_mode = 1;
        drain(3000, "t3_drain");
        chk("t3_frame_bytes", 32'(hs_cnt - hs0), 32'(2 * fl(255)));

        // Length queue overflow: nine 1-byte packets with ready low
        ready_mode = 0;
        for (int p = 0; p < 9; p++) begin
            pkt_data[0] = 8'(p + 1);
            send_pkt(1, 1, 1'b0);
        end
        repeat (3) tick();
        chk("t4_drop_cnt", 32'(o_drop_cnt), 32'(model_drops));
        chk("t4_drop_pulses", 32'(drop_pulses), 32'(model_drops));
        hs0 = hs_cnt;
        ready_mode = 1;
        drain(500, "t4_drain");
        chk("t4_frame_bytes", 32'(hs_cnt - hs0), 32'(8 * fl(1)));

        // Short packet dropped; len==0 packet ignored silently
        pkt_data[0] = 8'h01; pkt_data[1] = 8'h02;
        send_pkt(3, 2, 1'b0);
        repeat (2) tick();
        chk("t5_short_drop_cnt", 32'(o_drop_cnt), 32'(model_drops));
        send_pkt(0, 0, 1'b1);
        repeat (2) tick();
        chk("t5_len0_drop_cnt", 32'(o_drop_cnt), 32'(model_drops));
        chk("t5_len0_busy", 32'(o_busy), 32'd0);
        drain(100, "t5_drain");

        // Randomized packets: extra bytes, short packets, separate i_last
        ready_mode = 3;
        for (int p = 0; p < 25; p++) begin
            len = int'($urandom_range(1, 40));
            r   = int'($urandom_range(0, 9));
            n   = (r == 0 && len > 1) ? len - 1 : (r == 1) ? len + 2 : len;
            for (int b = 0; b < n; b++) pkt_data[b] = 8'($urandom);
            send_pkt(len, n, 1'($urandom_range(0, 1)));
            drain(500, "t6_drain");
        end
        chk("t6_drop_cnt", 32'(o_drop_cnt), 32'(model_drops));
        chk("t6_drop_pulses", 32'(drop_pulses), 32'(model_drops));

        // Reset in the middle of the payload, then a fresh 1-byte packet
        ready_mode = 1;
        for (int b = 0; b < 10; b++) pkt_data[b] = 8'(b + 8'h30);
        send_pkt(10, 10, 1'b0);
        k = 0;
        while (o_tx_valid !== 1'b1 && k < 20) begin tick(); k++; end
        chk("t7_start", 32'(k < 20), 32'd1);
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        chk("t7_rst_tx_valid", 32'(o_tx_valid), 32'd0);
        chk("t7_rst_tx_data", 32'(o_tx_data), 32'd0);
        chk("t7_rst_busy", 32'(o_busy), 32'd0);
        chk("t7_rst_drop_cnt", 32'(o_drop_cnt), 32'd0);
        chk("t7_rst_drop", 32'(o_drop), 32'd0);
        exp_q.delete();
        model_used = 0; model_out = 0; model_drops = 0; drop_pulses = 0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        pkt_data[0] = 8'hA5;
        send_pkt(1, 1, 1'b0);
        hs0 = hs_cnt;
        drain(100, "t7_drain");
        chk("t7_frame_bytes", 32'(hs_cnt - hs0), 32'(fl(1)));
        chk("t7_drop_cnt", 32'(o_drop_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
